// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side byte handshake into the buffered UART transmitter.
interface uart_tx_fifo_if;
   logic       tx_req;
   logic       tx_ready;
   logic [7:0] tx_data;
   modport master (output tx_req, tx_data, input tx_ready);
   modport slave (input tx_req, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data/parity/stop bits.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   uart_tx_fifo_if.slave                 bus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_busy,
   output logic                          uart_tx
`ifdef UART_TX_CTS_EN
   ,
   input  logic                          cts_n
`endif
);
   localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(STOP_BITS * DIV);
   localparam logic [CW-1:0] BIT_LD = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_LD = CW'(STOP_BITS * DIV - 1);
   localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [7:0]    shreg, head;
   logic [2:0]    bit_cnt;
   logic [CW-1:0] baud;
   logic          par_bit, avail, push, pop, tick, cts_ok;
`ifdef UART_TX_CTS_EN
   logic [1:0] cts_s;
   always_ff @(posedge clk)
      if (reset) cts_s <= 2'b11;
      else cts_s <= {cts_s[0], cts_n};
   assign cts_ok = !cts_s[1];
`else
   assign cts_ok = 1'b1;
`endif
   assign bus.tx_ready = (fifo_level != FULL) && !reset;
   assign push = bus.tx_req && bus.tx_ready;
   assign tick = baud == '0;
   assign pop = avail && cts_ok && (state == IDLE || (state == STOP && tick));
   assign tx_busy = state != IDLE || fifo_level != '0;
   assign head = mem[rptr] & MASK;
   always_ff @(posedge clk)
      if (push) mem[wptr] <= bus.tx_data;
   // avail trails the occupancy by one edge so a fresh byte starts on E+2
   always_ff @(posedge clk)
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         fifo_level <= '0;
         avail <= 1'b0;
      end else begin
         wptr <= push ? wptr + 1'b1 : wptr;
         rptr <= pop ? rptr + 1'b1 : rptr;
         fifo_level <= fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);
         avail <= fifo_level > (AW + 1)'(pop);
      end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         uart_tx <= 1'b1;
         baud <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         par_bit <= 1'b0;
      end else if (state == IDLE || tick) begin
         case (state)
            IDLE, STOP: begin
               if (pop) begin
                  shreg <= head;
                  par_bit <= ^head ^ (PARITY == 1);
                  uart_tx <= 1'b0;
                  baud <= BIT_LD;
                  bit_cnt <= '0;
                  state <= START;
               end else state <= IDLE;
            end
            START: begin
               state <= DATA;
               uart_tx <= shreg[0];
               baud <= BIT_LD;
            end
            DATA: begin
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
                  state <= PARITY != 0 ? PAR : STOP;
                  uart_tx <= PARITY != 0 ? par_bit : 1'b1;
                  baud <= PARITY != 0 ? BIT_LD : STOP_LD;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shreg <= shreg >> 1;
                  uart_tx <= shreg[1];
                  baud <= BIT_LD;
               end
            end
            PAR: begin
               state <= STOP;
               uart_tx <= 1'b1;
               baud <= STOP_LD;
            end
            default: state <= IDLE;
         endcase
      end else baud <= baud - 1'b1;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; dut_a is 8N1 depth 4, dut_b is 7E2 depth 4, both DIV=16.
module tb_uart_tx_fifo;
   logic clk = 0, reset = 1, cts_n = 0;
   logic [2:0] lvl_a, lvl_b;
   logic busy_a, busy_b, ua, ub;
   int cyc = 0, tests = 0, fails = 0;
   int sent_a = 0, sent_b = 0, done_a = 0, done_b = 0, maxl = 0;
   logic [7:0] qa[$], qb[$];
   int start_a[$], start_b[$];
   uart_tx_fifo_if ifa ();
   uart_tx_fifo_if ifb ();
   uart_tx_fifo #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa), .fifo_level(lvl_a), .tx_busy(busy_a), .uart_tx(ua)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );
   uart_tx_fifo #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb), .fifo_level(lvl_b), .tx_busy(busy_b), .uart_tx(ub)
`ifdef UART_TX_CTS_EN
      , .cts_n(cts_n)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask
   // Expected frame built from the byte alone; every cycle of every bit must match.
   task automatic rx(input int sel, input logic [7:0] b, output bit aborted);
      logic want[$];
      logic [15:0] wv = '0, gv = '0;
      logic [7:0] m = sel ? 8'h7f : 8'hff;
      logic l;
      bit ok = 1;
      aborted = 0;
      want.push_back(1'b0);
      for (int i = 0; i < (sel ? 7 : 8); i++) want.push_back(b[i]);
      if (sel) want.push_back(^(b & m));
      for (int i = 0; i < (sel ? 2 : 1); i++) want.push_back(1'b1);
      for (int k = 0; k < want.size(); k++) begin
         wv[k] = want[k];
         for (int c = 0; c < 16; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (reset) begin
               aborted = 1;
               return;
            end
            l = sel ? ub : ua;
            if (l !== want[k]) ok = 0;
            if (c == 8) gv[k] = l;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL frame_%s byte %02h: got bits %b required %b (LSB=start, any cycle off)",
                  sel ? "b" : "a", b, gv, wv);
      end
   endtask
   task automatic monitor(input int sel);
      logic [7:0] b;
      bit ab;
      forever begin
         @(negedge clk);
         if (!reset && (sel ? ub : ua) === 1'b0) begin
            if (sel) start_b.push_back(cyc);
            else start_a.push_back(cyc);
            if ((sel ? qb.size() : qa.size()) == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame_%0d: got start bit, required idle line", sel);
               repeat (16) @(negedge clk);
            end else begin
               b = sel ? qb.pop_front() : qa.pop_front();
               rx(sel, b, ab);
               if (sel) done_b++;
               else done_a++;
            end
         end
      end
   endtask
   initial monitor(0);
   initial monitor(1);
   // Called at a negedge; keeps tx_req high on return so bursts stay continuous.
   task automatic push(input int sel, input logic [7:0] b, output int acc);
      logic rdy;
      int n = 0;
      if (sel) begin
         ifb.tx_req = 1;
         ifb.tx_data = b;
      end else begin
         ifa.tx_req = 1;
         ifa.tx_data = b;
      end
      forever begin
         rdy = sel ? ifb.tx_ready : ifa.tx_ready;
         if (!sel) begin
            if (int'(lvl_a) > maxl) maxl = int'(lvl_a);
            chk("ready_vs_full", rdy, lvl_a != 3'd4);
         end
         @(posedge clk);
         if (rdy) break;
         @(negedge clk);
         if (++n > 500) begin
            chk("push_timeout", 0, 1);
            break;
         end
      end
      @(negedge clk);
      acc = cyc;
      if (sel) begin
         qb.push_back(b);
         sent_b++;
      end else begin
         qa.push_back(b);
         sent_a++;
      end
   endtask
   task automatic wait_done();
      int i = 0;
      while ((done_a != sent_a || done_b != sent_b) && i < 3000) begin
         @(negedge clk);
         i++;
      end
      chk("drain_done", (done_a == sent_a && done_b == sent_b), 1);
   endtask
   task automatic idle_a();
      ifa.tx_req = 0;
   endtask
   initial begin
      int acc, idx, n, d;
      logic [7:0] burst [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      ifa.tx_req = 0; ifa.tx_data = 0; ifb.tx_req = 0; ifb.tx_data = 0;
      repeat (3) @(negedge clk);
      chk("rst_uart_tx", ua, 1);
      chk("rst_level", lvl_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_ready", ifa.tx_ready, 0);
      reset = 0;
      @(negedge clk);
      chk("ready_after_rst", ifa.tx_ready, 1);
      // 0xA5 8N1: latency and busy fall
      idx = start_a.size();
      push(0, 8'hA5, acc);
      idle_a();
      while (cyc < acc + 161) @(negedge clk);
      chk("busy_in_stop", busy_a, 1);
      @(negedge clk);
      chk("busy_after_stop", busy_a, 0);
      wait_done();
      chk("start_latency", start_a[idx] - acc, 2);
      push(0, 8'h00, acc);
      push(0, 8'hFF, acc);
      idle_a();
      wait_done();
      // 7E2 on dut_b
      push(1, 8'h83, acc);
      push(1, 8'h07, acc);
      ifb.tx_req = 0;
      wait_done();
      // burst into depth-4 FIFO
      idx = start_a.size();
      maxl = 0;
      foreach (burst[i]) push(0, burst[i], acc);
      idle_a();
      wait_done();
      chk("level_max", maxl, 4);
      for (int i = 1; i < 6; i++) chk("b2b_gap", start_a[idx + i] - start_a[idx + i - 1], 160);
      // push on the STOP->START pop edge
      push(0, 8'h10, acc);
      push(0, 8'h11, d);
      push(0, 8'h12, d);
      idle_a();
      while (cyc < acc + 161) @(negedge clk);
      chk("level_before_pop", lvl_a, 2);
      push(0, 8'h13, d);
      idle_a();
      chk("push_on_pop_edge", d - acc, 162);
      chk("level_push_pop", lvl_a, 2);
      wait_done();
      // reset mid-DATA of 0x55
      push(0, 8'h55, acc);
      push(0, 8'hAA, d);
      push(0, 8'h0F, d);
      idle_a();
      while (cyc < acc + 2 + 16 * 3 + 5) @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("rst_mid_line", ua, 1);
      chk("rst_mid_level", lvl_a, 0);
      chk("rst_mid_ready", ifa.tx_ready, 0);
      reset = 0;
      sent_a -= qa.size();
      qa.delete();
      n = start_a.size();
      repeat (200) @(negedge clk);
      chk("no_frames_after_rst", start_a.size() - n, 0);
      chk("idle_after_rst", ua, 1);
      chk("busy_after_rst", busy_a, 0);
      push(0, 8'h42, acc);
      idle_a();
      wait_done();
`ifdef UART_TX_CTS_EN
      cts_n = 1;
      repeat (3) @(negedge clk);
      n = start_a.size();
      push(0, 8'h3C, acc);
      idle_a();
      repeat (40) @(negedge clk);
      chk("cts_hold_line", ua, 1);
      chk("cts_hold_busy", busy_a, 1);
      chk("cts_hold_nostart", start_a.size() - n, 0);
      cts_n = 0;
      d = cyc;
      repeat (6) @(negedge clk);
      chk("cts_started", start_a.size() - n, 1);
      if (start_a.size() > n) chk("cts_start_within_3", (start_a[n] - d) <= 3, 1);
      repeat (40) @(negedge clk);
      cts_n = 1;
      wait_done();
      cts_n = 0;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the fixed 8N1 transmitter. It buffers bytes in an internal FIFO and serialises them with configurable data bits, parity and stop bits. It sits between a producer (UART receiver, command engine) and the UART_TX pin, so bursts are absorbed without stalling the producer. Back-to-back frames leave no idle gap.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit, DIV >= 4 required
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entries, power of 2, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_req  input  1  producer has a byte on tx_data
tx_ready  output  1  FIFO can accept; byte written on an edge where tx_req && tx_ready
tx_data  input  8  byte; only bits [DATA_BITS-1:0] are transmitted
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty
uart_tx  output  1  serial line, idle high
cts_n  input  1  present only with UART_TX_CTS_EN, see Optional Feature

Behaviour:
- Reset (reset high at an edge): FIFO emptied, fifo_level=0, FSM=IDLE, uart_tx=1, tx_busy=0, bit counter and baud counter cleared. tx_ready=0 while reset is high and 1 on the first edge after release. Reset mid-frame aborts the frame; the line returns high on the reset edge.
- tx_ready = !full && !reset. A tx_req while full is ignored: nothing is written and data is not held by the block. The producer holds tx_req and tx_data until accepted.
- FIFO: write and read pointers of width $clog2(FIFO_DEPTH), wrapping naturally. Occupancy is tracked by a counter. A simultaneous push and pop leaves fifo_level unchanged. fifo_level = FIFO_DEPTH means full; 0 means empty.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if the FIFO is non-empty, pop the head into a shift register, drive uart_tx=0, load baud counter = DIV-1, go to START.
- Latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE produces uart_tx=0 from edge E+2.
- Every bit is held exactly DIV clocks. The baud counter counts down, and the bit advances at 0.
- DATA: LSB first, DATA_BITS bits. Then PAR if PARITY != 0, else STOP.
- PAR: odd parity gives XOR of the data bits inverted; even parity gives XOR of the data bits.
- STOP: uart_tx=1 for STOP_BITS*DIV clocks. On the final clock, if the FIFO is non-empty, pop and go directly to START (uart_tx=0 on the next edge, no idle cycle). Otherwise go to IDLE.
- tx_busy = (state != IDLE) || (fifo_level != 0).
- uart_tx is driven from a flop. It has no combinational path from any input.

Optional Feature:
Macro UART_TX_CTS_EN.
- Defined: port cts_n exists and passes through a 2-flop synchroniser; both flops reset to 1. A new frame (IDLE->START or STOP->START) starts only when synchronised cts_n = 0. Otherwise the FSM waits in IDLE with uart_tx=1. A frame already in progress always completes. tx_busy stays high while data waits.
- Not defined: no cts_n port, and frames start unconditionally.

Test Plan:
1. CLK_FREQ=1600, BAUD=100 (DIV=16), 8N1; push 0xA5 -> uart_tx low at E+2; bits 1,0,1,0,0,1,0,1 each for 16 clocks; stop high for 16 clocks; tx_busy falls after the stop bit.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2; push 0x83 -> 7 data bits 1,1,0,0,0,0,0; parity bit 0; high for 32 clocks.
3. FIFO_DEPTH=4; hold tx_req high with 0x01..0x06 while the line is busy -> tx_ready drops when fifo_level=4; all 6 bytes are sent in order; consecutive frames have the start bit immediately after the stop bit.
4. Reset pulse mid-DATA of 0x55 with 2 bytes queued -> uart_tx=1 and fifo_level=0 on the reset edge; no further frames; a push after release is transmitted normally.
5. Push on the same edge as the STOP->START pop with fifo_level=2 -> fifo_level stays 2.
6. With UART_TX_CTS_EN and cts_n=1, push 0x3C -> uart_tx stays high and tx_busy=1. Drop cts_n -> start bit within 3 clocks. Raise cts_n mid-frame -> the frame completes.
